verinject_injection_scheduler: RTL

//  Drives the shared verinject__injector_state bus read by every FF/memory injector in the design.

---
 rtl/verinject_injection_scheduler_pkg.sv | 25 ++
 rtl/verinject_injection_scheduler_if.sv | 25 ++
 rtl/verinject_injection_scheduler_fifo.sv | 43 ++++
 rtl/verinject_injection_scheduler.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/verinject_injection_scheduler_pkg.sv
// Shared codes, FSM states and command record for the verinject injection scheduler.
// Used by the scheduler top, its command FIFO and the command interface.
package verinject_pkg;

  localparam logic [31:0] IDLE_CODE  = 32'hFFFF_FFFF;
  localparam logic [31:0] CLEAR_CODE = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN
  } sched_state_t;

  // Timestamp is carried at its widest size; narrower schedulers zero-extend on entry.
  typedef struct packed {
    logic [63:0] cycle;
    logic [31:0] bit_idx;
  } cmd_t;

  // Codes at or above CLEAR_CODE are bus control words, not bit indices.
  function automatic logic is_reserved_bit(input logic [31:0] b);
    return (b >= CLEAR_CODE);
  endfunction

endpackage

// File: rtl/verinject_injection_scheduler_if.sv
// Timed-command push port of the injection scheduler: valid/ready plus (cycle, bit) payload.
interface verinject_injection_scheduler_if #(
  parameter int CYCLE_W = 32
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [CYCLE_W-1:0] cmd_cycle;
  logic [31:0]        cmd_bit;

  modport master (
    output cmd_valid,
    output cmd_cycle,
    output cmd_bit,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_cycle,
    input  cmd_bit,
    output cmd_ready
  );

endinterface

// File: rtl/verinject_injection_scheduler_fifo.sv
// Synchronous command FIFO with show-ahead head; a push on a full FIFO is legal when paired with a pop.
module verinject_sched_fifo
  import verinject_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  cmd_t push_data,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // On full, the slot being written is the head being popped; the old head is read before the edge.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/verinject_injection_scheduler.sv
// Injection scheduler: replays buffered (cycle, bit) commands onto the shared injector state bus.
// Optional trace outputs are enabled with VERINJECT_SCHED_TRACE_EN.
module verinject_injection_scheduler
  import verinject_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  verinject_injection_scheduler_if.slave  cmd,
  input  logic                            start,
  input  logic                            stop,
  output logic                            busy,
  output logic [CYCLE_W-1:0]              run_cycle,
  output logic [15:0]                     late_count,
  output logic [15:0]                     reject_count,
  output logic [31:0]                     verinject__injector_state
`ifdef VERINJECT_SCHED_TRACE_EN
  ,
  output logic                            trace_valid,
  output logic [CYCLE_W-1:0]              trace_cycle,
  output logic [31:0]                     trace_bit
`endif
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  sched_state_t state_q;
  sched_state_t state_d;

  cmd_t        head;
  cmd_t        push_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        due;
  logic        late_hit;
  logic        fire;
  logic        enter_clear;
  logic        accept;
  logic        rejected;
  logic        push;
  logic [31:0] bus_d;

  verinject_sched_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (fire),
    .push_data (push_data),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Stored timestamps are zero-extended, so the full-width compare equals the CYCLE_W compare.
  assign due      = !fifo_empty && (head.cycle <= 64'(run_cycle));
  assign late_hit = (head.cycle < 64'(run_cycle));

  always_comb begin
    state_d     = state_q;
    fire        = 1'b0;
    enter_clear = 1'b0;
    bus_d       = IDLE_CODE;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d     = S_CLEAR;
          enter_clear = 1'b1;
          bus_d       = CLEAR_CODE;
        end
      end
      S_CLEAR: begin
        state_d = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (due) begin
          fire  = 1'b1;
          bus_d = head.bit_idx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A firing cycle frees the head slot, so a full FIFO can still accept that cycle.
  assign cmd.cmd_ready   = !fifo_full || fire;
  assign accept          = cmd.cmd_valid && cmd.cmd_ready;
  assign rejected        = accept && is_reserved_bit(cmd.cmd_bit);
  assign push            = accept && !rejected;
  assign push_data.cycle   = 64'(cmd.cmd_cycle);
  assign push_data.bit_idx = cmd.cmd_bit;

  assign busy = (state_q != S_IDLE);

  // ---- stage boundary: registered FSM state, run counter, status counters and bus
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                   <= S_IDLE;
      run_cycle                 <= '0;
      late_count                <= '0;
      reject_count              <= '0;
      verinject__injector_state <= IDLE_CODE;
    end else begin
      state_q                   <= state_d;
      verinject__injector_state <= bus_d;
      if (enter_clear) begin
        run_cycle <= '0;
      end else if (state_q == S_RUN && !stop) begin
        run_cycle <= run_cycle + 1'b1;
      end
      if (fire && late_hit) late_count   <= sat_inc16(late_count);
      if (rejected)         reject_count <= sat_inc16(reject_count);
    end
  end

`ifdef VERINJECT_SCHED_TRACE_EN
  // ---- stage boundary: trace record aligned with the injection code on the bus
  always_ff @(posedge clock) begin
    if (reset) begin
      trace_valid <= 1'b0;
    end else begin
      trace_valid <= fire;
    end
  end

  always_ff @(posedge clock) begin
    if (fire) begin
      trace_cycle <= run_cycle;
      trace_bit   <= head.bit_idx;
    end
  end
`endif

endmodule
